// File: rtl/write_text_scaled_if.sv
// VGA timing/colour bundle passed between pipeline stages.
// The "in" modport is for consumers and the "out" modport is for producers.
interface vga_if;
    logic [11:0] hcount;
    logic [11:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/write_text_scaled.sv
// Scaled 8x16 text overlay with background box and frame-based blinking.
// Colours and enables are shadowed per frame and applied from the frame's first output pixel.
module write_text_scaled #(
    parameter int BEGIN_TXT_X  = 930,
    parameter int BEGIN_TXT_Y  = 20,
    parameter int COLS         = 32,
    parameter int ROWS         = 8,
    parameter int SCALE        = 1,
    parameter int FONT_LAT     = 2,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  en,
    input  logic                                  blink_en,
    input  logic                                  bg_en,
    input  logic [11:0]                           fg_rgb,
    input  logic [11:0]                           bg_rgb,
    input  logic [7:0]                            char_pixels,
    output logic [$clog2(ROWS)+$clog2(COLS)-1:0]  char_xy,
    output logic [3:0]                            char_line,
    vga_if.in                                     in,
    vga_if.out                                    out
);

    localparam int SH     = $clog2(SCALE);
    localparam int COLS_W = $clog2(COLS);
    localparam int ROWS_W = $clog2(ROWS);
    localparam int DLY    = FONT_LAT + 1;
    localparam int CW     = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [11:0] X0_12 = 12'(BEGIN_TXT_X);
    localparam logic [11:0] Y0_12 = 12'(BEGIN_TXT_Y);
    localparam logic [12:0] X0    = 13'(BEGIN_TXT_X);
    localparam logic [12:0] Y0    = 13'(BEGIN_TXT_Y);
    localparam logic [12:0] X1    = 13'(BEGIN_TXT_X + COLS * 8 * SCALE);
    localparam logic [12:0] Y1    = 13'(BEGIN_TXT_Y + ROWS * 16 * SCALE);
    localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_FRAMES - 1);

    typedef struct packed {
        logic [11:0] hcount;
        logic [11:0] vcount;
        logic        hsync;
        logic        vsync;
        logic        hblnk;
        logic        vblnk;
        logic [11:0] rgb;
    } timing_t;

    timing_t     in_t;
    timing_t     pipe [DLY];
    timing_t     tail;
    logic        fs_in;
    logic        fs_tail;

    logic [11:0] dx, dy, gx, gy;
    logic [11:0] dx_d, gx_d;
    logic [2:0]  bit_idx;
    logic        pixel;
    logic        in_win;
    logic [11:0] rgb_nxt;

    // Shadows are captured at the input frame start
    logic        sh_en, sh_blink, sh_bg_en, sh_hidden;
    logic [11:0] sh_fg, sh_bg;

    // Applied set follows the frame start through the pipeline
    logic        ap_en, ap_blink, ap_bg_en, ap_hidden;
    logic [11:0] ap_fg, ap_bg;

    logic        cur_en, cur_blink, cur_bg_en, cur_hidden;
    logic [11:0] cur_fg, cur_bg;

    logic [CW-1:0] blink_cnt;
    logic          blink_phase;

    always_comb begin
        in_t.hcount = in.hcount;
        in_t.vcount = in.vcount;
        in_t.hsync  = in.hsync;
        in_t.vsync  = in.vsync;
        in_t.hblnk  = in.hblnk;
        in_t.vblnk  = in.vblnk;
        in_t.rgb    = in.rgb;
        fs_in       = (in.hcount == '0) && (in.vcount == '0);
    end

    always_comb begin
        dx = in.hcount - X0_12;
        dy = in.vcount - Y0_12;
        gx = dx >> SH;
        gy = dy >> SH;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            char_xy   <= '0;
            char_line <= '0;
        end else begin
            char_xy   <= {gy[4 +: ROWS_W], gx[3 +: COLS_W]};
            char_line <= gy[3:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh_en     <= 1'b0;
            sh_blink  <= 1'b0;
            sh_bg_en  <= 1'b0;
            sh_fg     <= 12'hF00;
            sh_bg     <= 12'h000;
            sh_hidden <= 1'b0;
        end else if (fs_in) begin
            sh_en     <= en;
            sh_blink  <= blink_en;
            sh_bg_en  <= bg_en;
            sh_fg     <= fg_rgb;
            sh_bg     <= bg_rgb;
            // The frame shows the phase held before this frame's counter step
            sh_hidden <= blink_phase;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (fs_in) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DLY; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= in_t;
            for (int unsigned i = 1; i < DLY; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    always_comb begin
        tail    = pipe[DLY-1];
        fs_tail = (tail.hcount == '0) && (tail.vcount == '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ap_en     <= 1'b0;
            ap_blink  <= 1'b0;
            ap_bg_en  <= 1'b0;
            ap_fg     <= 12'hF00;
            ap_bg     <= 12'h000;
            ap_hidden <= 1'b0;
        end else if (fs_tail) begin
            ap_en     <= sh_en;
            ap_blink  <= sh_blink;
            ap_bg_en  <= sh_bg_en;
            ap_fg     <= sh_fg;
            ap_bg     <= sh_bg;
            ap_hidden <= sh_hidden;
        end
    end

    // The frame's first pixel must already see the new set, so bypass the applied registers
    always_comb begin
        cur_en     = fs_tail ? sh_en     : ap_en;
        cur_blink  = fs_tail ? sh_blink  : ap_blink;
        cur_bg_en  = fs_tail ? sh_bg_en  : ap_bg_en;
        cur_fg     = fs_tail ? sh_fg     : ap_fg;
        cur_bg     = fs_tail ? sh_bg     : ap_bg;
        cur_hidden = fs_tail ? sh_hidden : ap_hidden;
    end

    always_comb begin
        dx_d    = tail.hcount - X0_12;
        gx_d    = dx_d >> SH;
        bit_idx = ~gx_d[2:0];
        pixel   = char_pixels[bit_idx];
        in_win  = ({1'b0, tail.hcount} >= X0) && ({1'b0, tail.hcount} < X1) &&
                  ({1'b0, tail.vcount} >= Y0) && ({1'b0, tail.vcount} < Y1);
    end

    always_comb begin
        rgb_nxt = tail.rgb;
        if (in_win) begin
            if (tail.hblnk || tail.vblnk) begin
                rgb_nxt = 12'h000;
            end else if (!cur_en || (cur_blink && cur_hidden)) begin
                rgb_nxt = tail.rgb;
            end else if (pixel) begin
                rgb_nxt = cur_fg;
            end else if (cur_bg_en) begin
                rgb_nxt = cur_bg;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out.hcount <= '0;
            out.vcount <= '0;
            out.hsync  <= 1'b0;
            out.vsync  <= 1'b0;
            out.hblnk  <= 1'b0;
            out.vblnk  <= 1'b0;
            out.rgb    <= '0;
        end else begin
            out.hcount <= tail.hcount;
            out.vcount <= tail.vcount;
            out.hsync  <= tail.hsync;
            out.vsync  <= tail.vsync;
            out.hblnk  <= tail.hblnk;
            out.vblnk  <= tail.vblnk;
            out.rgb    <= rgb_nxt;
        end
    end

endmodule

// File: tb/tb_write_text_scaled.sv
// Directed bench for write_text_scaled: one unscaled instance at (930,20) and one
// SCALE=2 instance at (0,0), both with BLINK_FRAMES=2 and sharing the input bus.
module tb_write_text_scaled;

    logic        clk = 1'b0;
    logic        rst;
    logic        en, blink_en, bg_en;
    logic [11:0] fg_rgb, bg_rgb;
    logic [7:0]  char_pixels;
    logic [7:0]  xy_a, xy_b;
    logic [3:0]  line_a, line_b;

    int checks = 0;
    int errors = 0;

    vga_if vin ();
    vga_if va_out ();
    vga_if vb_out ();

    always #5 clk = ~clk;

    write_text_scaled #(
        .BEGIN_TXT_X(930), .BEGIN_TXT_Y(20), .COLS(32), .ROWS(8),
        .SCALE(1), .FONT_LAT(2), .BLINK_FRAMES(2)
    ) dut_a (
        .clk(clk), .rst(rst), .en(en), .blink_en(blink_en), .bg_en(bg_en),
        .fg_rgb(fg_rgb), .bg_rgb(bg_rgb), .char_pixels(char_pixels),
        .char_xy(xy_a), .char_line(line_a), .in(vin), .out(va_out)
    );

    write_text_scaled #(
        .BEGIN_TXT_X(0), .BEGIN_TXT_Y(0), .COLS(32), .ROWS(8),
        .SCALE(2), .FONT_LAT(2), .BLINK_FRAMES(2)
    ) dut_b (
        .clk(clk), .rst(rst), .en(en), .blink_en(blink_en), .bg_en(bg_en),
        .fg_rgb(fg_rgb), .bg_rgb(bg_rgb), .char_pixels(char_pixels),
        .char_xy(xy_b), .char_line(line_b), .in(vin), .out(vb_out)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_px(input logic [11:0] h, input logic [11:0] v, input logic [11:0] rgb,
                          input logic hb, input logic vb);
        vin.hcount = h;
        vin.vcount = v;
        vin.rgb    = rgb;
        vin.hblnk  = hb;
        vin.vblnk  = vb;
        vin.hsync  = 1'b0;
        vin.vsync  = 1'b0;
    endtask

    task automatic filler();
        set_px(12'd2000, 12'd1000, 12'hABC, 1'b0, 1'b0);
    endtask

    // One pixel through the 4-clock pipeline; returns both instances' colours
    task automatic pix(input logic [11:0] h, input logic [11:0] v, input logic [11:0] rgb,
                       input logic hb, input logic vb,
                       output logic [11:0] ra, output logic [11:0] rb);
        set_px(h, v, rgb, hb, vb);
        tick();
        filler();
        repeat (3) tick();
        ra = va_out.rgb;
        rb = vb_out.rgb;
    endtask

    task automatic frame_start();
        set_px(12'd0, 12'd0, 12'h000, 1'b0, 1'b0);
        tick();
        filler();
        repeat (3) tick();
    endtask

    task automatic test_reset();
        logic [11:0] ra, rb;
        rst = 1'b0;
        en = 1'b1; blink_en = 1'b0; bg_en = 1'b0;
        fg_rgb = 12'hF00; bg_rgb = 12'h000; char_pixels = 8'hFF;
        set_px(12'd940, 12'd40, 12'hFFF, 1'b1, 1'b1);
        vin.hsync = 1'b1; vin.vsync = 1'b1;
        repeat (5) tick();
        checks++;
        if ({va_out.hcount, va_out.vcount, va_out.hsync, va_out.vsync, va_out.hblnk,
             va_out.vblnk, va_out.rgb} !== 40'd0) begin
            errors++;
            $display("FAIL reset_out_a: got %h/%h/%h expected all zero",
                     va_out.hcount, va_out.vcount, va_out.rgb);
        end
        checks++;
        if ({vb_out.hcount, vb_out.vcount, vb_out.hsync, vb_out.vsync, vb_out.hblnk,
             vb_out.vblnk, vb_out.rgb} !== 40'd0) begin
            errors++;
            $display("FAIL reset_out_b: got %h/%h/%h expected all zero",
                     vb_out.hcount, vb_out.vcount, vb_out.rgb);
        end
        checks++;
        if (xy_a !== 8'h00 || line_a !== 4'h0) begin
            errors++;
            $display("FAIL reset_addr: got xy=%h line=%h expected 00/0", xy_a, line_a);
        end
        rst = 1'b1;
        // Overlay is still off before the first frame start even with en=1 and a set glyph bit
        char_pixels = 8'h80;
        pix(12'd938, 12'd37, 12'h123, 1'b0, 1'b0, ra, rb);
        checks++;
        if (ra !== 12'h123) begin
            errors++;
            $display("FAIL reset_no_draw: got %h expected %h", ra, 12'h123);
        end
    endtask

    task automatic test_passthrough();
        logic [11:0] vals [12];
        for (int i = 0; i < 12; i++) begin
            vals[i] = 12'(12'h111 * (i + 1) + 7);
        end
        for (int i = 0; i < 12; i++) begin
            set_px(12'(100 + i), 12'd500, vals[i], 1'b0, 1'b0);
            vin.hsync = i[0];
            tick();
            if (i >= 3) begin
                checks++;
                if (va_out.rgb !== vals[i-3] || va_out.hcount !== 12'(100 + i - 3) ||
                    va_out.hsync !== 1'(i - 3)) begin
                    errors++;
                    $display("FAIL pass_delay[%0d]: got rgb=%h h=%0d hs=%b expected rgb=%h h=%0d hs=%b",
                             i, va_out.rgb, va_out.hcount, va_out.hsync, vals[i-3], 100 + i - 3,
                             1'(i - 3));
                end
            end
        end
        filler();
    endtask

    task automatic test_addressing();
        logic [11:0] ra, rb;
        logic [11:0] th [10];
        logic [11:0] tv [10];
        logic [11:0] te [10];
        frame_start();
        char_pixels = 8'h80;
        set_px(12'd938, 12'd37, 12'h123, 1'b0, 1'b0);
        tick();
        checks++;
        if (xy_a !== 8'h21 || line_a !== 4'd1) begin
            errors++;
            $display("FAIL addr_xy: got xy=%h line=%0d expected 21/1", xy_a, line_a);
        end
        filler();
        repeat (3) tick();
        checks++;
        if (va_out.rgb !== 12'hF00) begin
            errors++;
            $display("FAIL addr_glyph: got %h expected F00", va_out.rgb);
        end
        pix(12'd939, 12'd37, 12'h123, 1'b0, 1'b0, ra, rb);
        checks++;
        if (ra !== 12'h123) begin
            errors++;
            $display("FAIL addr_clear_bit: got %h expected 123", ra);
        end
        // Window edges with every glyph bit set
        char_pixels = 8'hFF;
        th = '{12'd929, 12'd930, 12'd1185, 12'd1186, 12'd940, 12'd940, 12'd940, 12'd940, 12'd930, 12'd1185};
        tv = '{12'd40,  12'd40,  12'd40,   12'd40,   12'd19,  12'd20,  12'd147, 12'd148, 12'd147, 12'd20};
        te = '{12'h123, 12'hF00, 12'hF00,  12'h123,  12'h123, 12'hF00, 12'hF00,  12'h123, 12'hF00, 12'hF00};
        for (int i = 0; i < 10; i++) begin
            pix(th[i], tv[i], 12'h123, 1'b0, 1'b0, ra, rb);
            checks++;
            if (ra !== te[i]) begin
                errors++;
                $display("FAIL addr_edge(%0d,%0d): got %h expected %h", th[i], tv[i], ra, te[i]);
            end
        end
    endtask

    task automatic test_scale();
        logic [11:0] ra, rb;
        logic [11:0] th [4];
        logic [11:0] tv [3];
        logic [3:0]  tl [3];
        logic [11:0] te [4];
        char_pixels = 8'h80;
        th = '{12'd0, 12'd1, 12'd2, 12'd3};
        te = '{12'hF00, 12'hF00, 12'h123, 12'h123};
        for (int i = 0; i < 4; i++) begin
            pix(th[i], 12'd2, 12'h123, 1'b0, 1'b0, ra, rb);
            checks++;
            if (rb !== te[i]) begin
                errors++;
                $display("FAIL scale_bit7 h=%0d: got %h expected %h", th[i], rb, te[i]);
            end
        end
        char_pixels = 8'h40;
        te = '{12'h123, 12'h123, 12'hF00, 12'hF00};
        for (int i = 0; i < 4; i++) begin
            pix(th[i], 12'd2, 12'h123, 1'b0, 1'b0, ra, rb);
            checks++;
            if (rb !== te[i]) begin
                errors++;
                $display("FAIL scale_bit6 h=%0d: got %h expected %h", th[i], rb, te[i]);
            end
        end
        tv = '{12'd2, 12'd3, 12'd4};
        tl = '{4'd1, 4'd1, 4'd2};
        for (int i = 0; i < 3; i++) begin
            set_px(12'd5, tv[i], 12'h123, 1'b0, 1'b0);
            tick();
            checks++;
            if (line_b !== tl[i]) begin
                errors++;
                $display("FAIL scale_line v=%0d: got %0d expected %0d", tv[i], line_b, tl[i]);
            end
        end
        set_px(12'd16, 12'd32, 12'h123, 1'b0, 1'b0);
        tick();
        checks++;
        if (xy_b !== 8'h21) begin
            errors++;
            $display("FAIL scale_xy: got %h expected 21", xy_b);
        end
        filler();
        char_pixels = 8'h01;
        pix(12'd511, 12'd2, 12'h123, 1'b0, 1'b0, ra, rb);
        checks++;
        if (rb !== 12'hF00) begin
            errors++;
            $display("FAIL scale_right_in: got %h expected F00", rb);
        end
        pix(12'd512, 12'd2, 12'h123, 1'b0, 1'b0, ra, rb);
        checks++;
        if (rb !== 12'h123) begin
            errors++;
            $display("FAIL scale_right_out: got %h expected 123", rb);
        end
    endtask

    task automatic test_shadow();
        logic [11:0] ra, rb;
        logic [11:0] te [5];
        char_pixels = 8'h80;
        te = '{12'hF00, 12'h0F0, 12'h0F0, 12'h123, 12'h0F0};
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: fg_rgb = 12'h0F0;
                1: frame_start();
                2: en = 1'b0;
                3: frame_start();
                default: begin en = 1'b1; frame_start(); end
            endcase
            pix(12'd938, 12'd37, 12'h123, 1'b0, 1'b0, ra, rb);
            checks++;
            if (ra !== te[i]) begin
                errors++;
                $display("FAIL shadow_step%0d: got %h expected %h", i, ra, te[i]);
            end
        end
    endtask

    task automatic test_blink();
        logic [11:0] ra, rb;
        logic [7:0]  hidden;
        logic [11:0] exp_rgb;
        char_pixels = 8'h80;
        set_px(12'd940, 12'd40, 12'h555, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (va_out.rgb !== 12'h000) begin
            errors++;
            $display("FAIL blink_async_reset: got %h expected 000", va_out.rgb);
        end
        tick();
        rst = 1'b1;
        filler();
        en = 1'b1; blink_en = 1'b1; fg_rgb = 12'hF00;
        // Frames 0..5 with blink on, 6..7 with blink off; bit set = hidden
        hidden = 8'b0000_1100;
        for (int f = 0; f < 8; f++) begin
            if (f == 6) blink_en = 1'b0;
            frame_start();
            pix(12'd938, 12'd37, 12'h123, 1'b0, 1'b0, ra, rb);
            exp_rgb = hidden[f] ? 12'h123 : 12'hF00;
            checks++;
            if (ra !== exp_rgb) begin
                errors++;
                $display("FAIL blink_frame%0d: got %h expected %h", f, ra, exp_rgb);
            end
        end
    endtask

    task automatic test_bg_blank();
        logic [11:0] ra, rb;
        bg_en = 1'b1; bg_rgb = 12'h00F; char_pixels = 8'h00;
        frame_start();
        pix(12'd940, 12'd40, 12'h123, 1'b0, 1'b0, ra, rb);
        checks++;
        if (ra !== 12'h00F) begin
            errors++;
            $display("FAIL bg_fill: got %h expected 00F", ra);
        end
        pix(12'd940, 12'd40, 12'h123, 1'b1, 1'b0, ra, rb);
        checks++;
        if (ra !== 12'h000) begin
            errors++;
            $display("FAIL bg_hblnk: got %h expected 000", ra);
        end
        pix(12'd940, 12'd40, 12'h123, 1'b0, 1'b1, ra, rb);
        checks++;
        if (ra !== 12'h000) begin
            errors++;
            $display("FAIL bg_vblnk: got %h expected 000", ra);
        end
        pix(12'd100, 12'd500, 12'h123, 1'b1, 1'b0, ra, rb);
        checks++;
        if (ra !== 12'h123) begin
            errors++;
            $display("FAIL bg_blank_outside: got %h expected 123", ra);
        end
        bg_en = 1'b0;
        frame_start();
        pix(12'd940, 12'd40, 12'h123, 1'b0, 1'b0, ra, rb);
        checks++;
        if (ra !== 12'h123) begin
            errors++;
            $display("FAIL bg_off: got %h expected 123", ra);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_passthrough();
        test_addressing();
        test_scale();
        test_shadow();
        test_blink();
        test_bg_blank();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
